// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data-memory access sizes and the data-memory
// handshake states, used by Control and by data_mem_responder.
package cpu_pkg;

  typedef enum logic [1:0] {
    DM_WORD = 2'b00,
    DM_HALF = 2'b01,
    DM_BYTE = 2'b10,
    DM_RSVD = 2'b11
  } dm_op_e;

  typedef enum logic [1:0] {
    DM_ST_IDLE = 2'b00,
    DM_ST_WAIT = 2'b01,
    DM_ST_RESP = 2'b10
  } dm_state_e;

  localparam int DM_CNT_W = 4;

  // The reserved size encoding behaves exactly like a full word.
  function automatic dm_op_e dm_op_norm(input logic [1:0] op);
    dm_op_e r;
    case (op)
      2'b01:   r = DM_HALF;
      2'b10:   r = DM_BYTE;
      default: r = DM_WORD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dm_lane_unit.sv
// Byte-lane logic for the data memory: store byte enables and lane-replicated
// write data, load lane extraction with zero extension, misalignment detect.
module dm_lane_unit
  import cpu_pkg::*;
(
  input  logic [1:0]  dm_op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  dm_op_e op;
  assign op = dm_op_norm(dm_op);

  // Word ignores addr[1:0] and half ignores addr[0]; the caller decides
  // whether an offending offset is an error.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign be[gi] = (op == DM_WORD) ||
                      ((op == DM_HALF) && (addr_lo[1] == LANE[1])) ||
                      ((op == DM_BYTE) && (addr_lo == LANE));
      assign wword[8*gi +: 8] = (op == DM_BYTE) ? wdata[7:0] :
                                (op == DM_HALF) ? wdata[8*(gi%2) +: 8] :
                                                  wdata[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    rdata_ext  = rword;
    misaligned = 1'b0;
    case (op)
      DM_HALF: begin
        rdata_ext  = {16'h0000, (addr_lo[1] ? rword[31:16] : rword[15:0])};
        misaligned = addr_lo[0];
      end
      DM_BYTE: begin
        rdata_ext  = {24'h000000, rword[{addr_lo, 3'b000} +: 8]};
      end
      default: begin
        misaligned = (addr_lo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data memory with a fixed-latency req/ready handshake and byte/half/word access.
// Define DM_ALIGN_CHECK_EN to flag misaligned word/half accesses via err.
module data_mem_responder
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  dm_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int DEPTH = 1 << ADDR_W;

  dm_state_e           state_q, state_d;
  logic [DM_CNT_W-1:0] cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [1:0]          op_q, op_d;
  logic [ADDR_W-1:0]   widx_q, widx_d;
  logic [1:0]          lo_q, lo_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                accept;

  logic [31:0]         mem [DEPTH];
  logic [31:0]         rword_q;
  logic [ADDR_W-1:0]   rd_idx;

  logic [3:0]          lane_be;
  logic [31:0]         lane_wword;
  logic [31:0]         lane_rdata;
  logic                lane_mis;
  logic                blocked;
  logic                wr_en;

  logic                unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

  assign rd_idx = addr[ADDR_W+1:2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= DM_ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      op_q    <= 2'b00;
      widx_q  <= '0;
      lo_q    <= 2'b00;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      op_q    <= op_d;
      widx_q  <= widx_d;
      lo_q    <= lo_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    op_d    = op_q;
    widx_d  = widx_q;
    lo_d    = lo_q;
    wdata_d = wdata_q;
    accept  = 1'b0;
    case (state_q)
      DM_ST_IDLE: begin
        if (req) begin
          accept  = 1'b1;
          we_d    = we;
          op_d    = dm_op;
          widx_d  = addr[ADDR_W+1:2];
          lo_d    = addr[1:0];
          wdata_d = wdata;
          cnt_d   = DM_CNT_W'(LATENCY);
          state_d = (LATENCY == 0) ? DM_ST_RESP : DM_ST_WAIT;
        end
      end
      DM_ST_WAIT: begin
        // The counter holds the WAIT cycles still to spend, this one included.
        cnt_d = cnt_q - DM_CNT_W'(1);
        if (cnt_q <= DM_CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = DM_ST_RESP;
        end
      end
      DM_ST_RESP: begin
        state_d = DM_ST_IDLE;
      end
      default: begin
        state_d = DM_ST_IDLE;
      end
    endcase
  end

  dm_lane_unit u_lane (
    .dm_op      (op_q),
    .addr_lo    (lo_q),
    .wdata      (wdata_q),
    .rword      (rword_q),
    .be         (lane_be),
    .wword      (lane_wword),
    .rdata_ext  (lane_rdata),
    .misaligned (lane_mis)
  );

`ifdef DM_ALIGN_CHECK_EN
  assign blocked = lane_mis;
`else
  logic unused_lane_mis;
  assign unused_lane_mis = lane_mis;
  assign blocked         = 1'b0;
`endif

  always_comb begin
    ready = (state_q == DM_ST_RESP);
    err   = ready && blocked;
    rdata = '0;
    if (ready && !we_q && !blocked) begin
      rdata = lane_rdata;
    end
  end

  // Only one access is ever in flight, so the word read at acceptance is
  // still current when the response is formed.
  assign wr_en = ready && we_q && !blocked;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_be[i]) begin
          mem[widx_q][8*i +: 8] <= lane_wword[8*i +: 8];
        end
      end
    end
    if (accept) begin
      rword_q <= mem[rd_idx];
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: byte-addressed reference model with a per-cycle
// monitor on a LATENCY=2 instance, plus directed checks on a LATENCY=0 instance.
module tb_data_mem_responder;

  localparam int LAT_A = 2;
`ifdef DM_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        req_a = 1'b0, we_a = 1'b0;
  logic [1:0]  op_a = 2'b00;
  logic [31:0] addr_a = '0, wdata_a = '0;
  logic        ready_a, err_a;
  logic [31:0] rdata_a;

  logic        req_b = 1'b0, we_b = 1'b0;
  logic [1:0]  op_b = 2'b00;
  logic [31:0] addr_b = '0, wdata_b = '0;
  logic        ready_b, err_b;
  logic [31:0] rdata_b;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(10), .LATENCY(LAT_A)) u_dut_a (
    .clk(clk), .reset(reset), .req(req_a), .we(we_a), .dm_op(op_a),
    .addr(addr_a), .wdata(wdata_a), .ready(ready_a), .rdata(rdata_a), .err(err_a)
  );

  data_mem_responder #(.ADDR_W(10), .LATENCY(0)) u_dut_b (
    .clk(clk), .reset(reset), .req(req_b), .we(we_b), .dm_op(op_b),
    .addr(addr_b), .wdata(wdata_b), .ready(ready_b), .rdata(rdata_b), .err(err_b)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check32(name, {31'b0, act}, {31'b0, exp});
  endtask

  // ---------------- reference model: byte-addressed, little-endian ----------
  logic [7:0]  mem_b [4096];
  bit          pend_valid = 1'b0;
  int          pend_due = 0;
  bit          pend_we = 1'b0;
  bit          pend_err = 1'b0;
  int          pend_base = 0;
  int          pend_size = 0;
  logic [31:0] pend_wd = '0;
  logic [31:0] pend_rdata = '0;

  function automatic int acc_size(input logic [1:0] op);
    case (op)
      2'b01:   return 2;
      2'b10:   return 1;
      default: return 4;
    endcase
  endfunction

  function automatic bit acc_misaligned(input logic [1:0] op, input logic [31:0] a);
    return ALIGN_CHECK && ((int'(a[1:0]) % acc_size(op)) != 0);
  endfunction

  function automatic int acc_base(input logic [1:0] op, input logic [31:0] a);
    return int'(a[11:0]) & ~(acc_size(op) - 1);
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] op, input logic [31:0] a);
    logic [31:0] v;
    int b;
    v = '0;
    b = acc_base(op, a);
    for (int i = 0; i < acc_size(op); i++) v[8*i +: 8] = mem_b[b + i];
    return v;
  endfunction

  initial begin
    for (int i = 0; i < 4096; i++) mem_b[i] = 8'h00;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_valid <= 1'b0;
    end else if (pend_valid) begin
      if (cyc == pend_due) begin
        pend_valid <= 1'b0;
        if (pend_we && !pend_err) begin
          for (int i = 0; i < pend_size; i++) mem_b[pend_base + i] <= pend_wd[8*i +: 8];
        end
      end
    end else if (req_a) begin
      pend_valid <= 1'b1;
      pend_due   <= cyc + LAT_A + 1;
      pend_we    <= we_a;
      pend_err   <= acc_misaligned(op_a, addr_a);
      pend_base  <= acc_base(op_a, addr_a);
      pend_size  <= acc_size(op_a);
      pend_wd    <= wdata_a;
      pend_rdata <= (we_a || acc_misaligned(op_a, addr_a)) ? 32'h0 : model_load(op_a, addr_a);
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check1("mon_ready", ready_a, pend_valid && (cyc == pend_due));
      check32("mon_rdata", rdata_a, (pend_valid && (cyc == pend_due)) ? pend_rdata : 32'h0);
      check1("mon_err", err_a, pend_valid && (cyc == pend_due) && pend_err);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic acc_a(input bit w, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd, output logic er,
                       output int lat);
    int t0;
    int n;
    @(negedge clk);
    req_a = 1'b1; we_a = w; op_a = op; addr_a = a; wdata_a = d;
    t0 = cyc;
    @(negedge clk);
    // Scramble the inputs so a design that fails to latch them is caught.
    req_a = 1'b0; we_a = ~w; op_a = ~op; addr_a = ~a; wdata_a = ~d;
    n = 0;
    while (ready_a !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    lat = cyc - t0;
    rd  = rdata_a;
    er  = err_a;
    if (ready_a !== 1'b1) begin
      n_checks++;
      n_errors++;
      $display("FAIL ready_timeout: got no ready, expected ready within 40 cycles (addr 0x%08h)", a);
    end
  endtask

  task automatic run_a(input string name, input bit w, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd;
    logic er;
    int lat;
    acc_a(w, op, a, d, rd, er, lat);
    $display("txn %s we=%0d op=%0d addr=0x%08h wdata=0x%08h -> rdata=0x%08h err=%0d lat=%0d",
             name, w, op, a, d, rd, er, lat);
    check32({name, "_rdata"}, rd, exp_rd);
    check1({name, "_err"}, er, exp_err);
    check32({name, "_lat"}, lat, 32'd3);
  endtask

  initial begin
    int pulses;
    int n;

    #1 reset = 1'b1;
    #1;
    check1("rst_ready_a", ready_a, 1'b0);
    check32("rst_rdata_a", rdata_a, 32'h0);
    check1("rst_err_a", err_a, 1'b0);
    check1("rst_ready_b", ready_b, 1'b0);
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;

    run_a("st_w_10",    1'b1, 2'b00, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    run_a("ld_w_10",    1'b0, 2'b00, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    run_a("st_w_10b",   1'b1, 2'b00, 32'h10, 32'h11223344, 32'h0, 1'b0);
    run_a("st_b_13",    1'b1, 2'b10, 32'h13, 32'h123456AA, 32'h0, 1'b0);
    run_a("ld_w_10b",   1'b0, 2'b00, 32'h10, 32'h0, 32'hAA223344, 1'b0);
    run_a("ld_b_13",    1'b0, 2'b10, 32'h13, 32'h0, 32'h000000AA, 1'b0);
    run_a("st_w_10c",   1'b1, 2'b00, 32'h10, 32'h11223344, 32'h0, 1'b0);
    run_a("st_h_12",    1'b1, 2'b01, 32'h12, 32'hFFFF5566, 32'h0, 1'b0);
    run_a("ld_h_12",    1'b0, 2'b01, 32'h12, 32'h0, 32'h00005566, 1'b0);
    run_a("ld_w_10c",   1'b0, 2'b00, 32'h10, 32'h0, 32'h55663344, 1'b0);
    run_a("ld_h_10",    1'b0, 2'b01, 32'h10, 32'h0, 32'h00003344, 1'b0);
    run_a("ld_b_11",    1'b0, 2'b10, 32'h11, 32'h0, 32'h00000033, 1'b0);
    run_a("st_rsvd_14", 1'b1, 2'b11, 32'h14, 32'hA5A55A5A, 32'h0, 1'b0);
    run_a("ld_w_14",    1'b0, 2'b00, 32'h14, 32'h0, 32'hA5A55A5A, 1'b0);
    run_a("ld_rsvd_14", 1'b0, 2'b11, 32'h14, 32'h0, 32'hA5A55A5A, 1'b0);

    run_a("st_w_11",    1'b1, 2'b00, 32'h11, 32'hFFFFFFFF, 32'h0, ALIGN_CHECK);
    run_a("ld_w_10d",   1'b0, 2'b00, 32'h10, 32'h0,
          ALIGN_CHECK ? 32'h55663344 : 32'hFFFFFFFF, 1'b0);
    run_a("ld_h_13",    1'b0, 2'b01, 32'h13, 32'h0,
          ALIGN_CHECK ? 32'h0 : 32'h0000FFFF, ALIGN_CHECK);

    run_a("st_w_1018",  1'b1, 2'b00, 32'h1018, 32'h0F0F1234, 32'h0, 1'b0);
    run_a("ld_w_18",    1'b0, 2'b00, 32'h18, 32'h0, 32'h0F0F1234, 1'b0);
    run_a("ld_b_hi",    1'b0, 2'b10, 32'hFFFFF01A, 32'h0, 32'h0000000F, 1'b0);

    // Reset during WAIT of a store: no response, no write.
    run_a("st_w_20",    1'b1, 2'b00, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0);
    @(negedge clk);
    req_a = 1'b1; we_a = 1'b1; op_a = 2'b00; addr_a = 32'h20; wdata_a = 32'h12345678;
    @(negedge clk);
    req_a = 1'b0;
    #1 reset = 1'b1;
    pulses = 0;
    repeat (2) begin
      @(negedge clk);
      if (ready_a) pulses++;
    end
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (ready_a) pulses++;
    end
    $display("txn rst_in_wait store 0x12345678 @0x20 -> ready pulses=%0d", pulses);
    check32("rst_wait_pulses", pulses, 32'd0);
    run_a("ld_w_20",    1'b0, 2'b00, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0);

    // Reset in the RESP cycle clears the outputs without waiting for a clock.
    @(negedge clk);
    req_a = 1'b1; we_a = 1'b0; op_a = 2'b00; addr_a = 32'h20;
    @(negedge clk);
    req_a = 1'b0;
    n = 0;
    while (ready_a !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check1("resp_before_rst", ready_a, 1'b1);
    check32("resp_rdata_before_rst", rdata_a, 32'hCAFEF00D);
    #2 reset = 1'b1;
    #1;
    $display("txn rst_in_resp -> ready=%0d rdata=0x%08h err=%0d", ready_a, rdata_a, err_a);
    check1("async_rst_ready", ready_a, 1'b0);
    check32("async_rst_rdata", rdata_a, 32'h0);
    check1("async_rst_err", err_a, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Request held high: one idle cycle between responses.
    @(negedge clk);
    req_a = 1'b1; we_a = 1'b0; op_a = 2'b00; addr_a = 32'h10;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (ready_a) pulses++;
    end
    req_a = 1'b0;
    $display("txn held_req_a 12 cycles -> ready pulses=%0d", pulses);
    check32("held_req_pulses_a", pulses, 32'd3);
    n = 0;
    while (pend_valid && n < 20) begin
      @(negedge clk);
      n++;
    end

    // LATENCY=0 instance: ready one cycle after acceptance; 0x1000 aliases 0x0.
    @(negedge clk);
    req_b = 1'b1; we_b = 1'b1; op_b = 2'b00; addr_b = 32'h0; wdata_b = 32'h0BADF00D;
    @(negedge clk);
    req_b = 1'b0; we_b = 1'b0;
    $display("txn b_st_w_0 -> ready=%0d rdata=0x%08h", ready_b, rdata_b);
    check1("b_st_ready", ready_b, 1'b1);
    check32("b_st_rdata", rdata_b, 32'h0);
    @(negedge clk);
    check1("b_idle_ready", ready_b, 1'b0);
    @(negedge clk);
    req_b = 1'b1; we_b = 1'b0; op_b = 2'b00; addr_b = 32'h1000;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      $display("txn b_held_ld_1000 k=%0d -> ready=%0d rdata=0x%08h err=%0d", k, ready_b, rdata_b, err_b);
      check1("b_held_ready", ready_b, (k % 2) == 1);
      check32("b_held_rdata", rdata_b, ((k % 2) == 1) ? 32'h0BADF00D : 32'h0);
      check1("b_held_err", err_b, 1'b0);
    end
    req_b = 1'b0;

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
